// File: rtl/sll_seq.sv
// Multi-cycle logical shift-left unit with a start/busy/done handshake.
// Define SLL_SEQ_FAST_EN to shift up to four bits per cycle instead of one.
module sll_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] acc_reg;
  logic [4:0]  cnt_reg;
  logic [4:0]  amt;
  logic        unused_b_hi;

  // A zero immediate means the amount comes from the register operand.
  assign amt         = (shamt != 5'd0) ? shamt : b[4:0];
  assign unused_b_hi = ^b[31:5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= 32'd0;
      cnt_reg   <= 5'd0;
      out       <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            acc_reg   <= a;
            cnt_reg   <= amt;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt_reg == 5'd0) begin
            out       <= acc_reg;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= DONE;
          end else begin
`ifdef SLL_SEQ_FAST_EN
            if (cnt_reg > 5'd4) begin
              acc_reg <= acc_reg << 4;
              cnt_reg <= cnt_reg - 5'd4;
            end else begin
              acc_reg <= acc_reg << cnt_reg;
              cnt_reg <= 5'd0;
            end
`else
            acc_reg <= acc_reg << 1;
            cnt_reg <= cnt_reg - 5'd1;
`endif
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
